// File: rtl/addr_gen_pkg.sv
// addr_gen_pkg: state encoding and counter sizing shared by the addr_gen family
package addr_gen_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  function automatic int ctr_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/addr_gen_seq_if.sv
// addr_gen_seq_if: sequencer control/config in, RAM-facing address stream out
interface addr_gen_seq_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int STRIDE_W = 8,
  parameter int CNT_W = 8,
  parameter int REP_W = 4
);
  logic en, i_start, i_abort, i_loop;
  logic [ADDR_WIDTH-1:0] i_base, i_len, o_addr;
  logic [STRIDE_W-1:0] i_stride;
  logic [CNT_W-1:0] i_dwell, i_pause;
  logic [REP_W-1:0] i_repeat;
  logic o_valid, o_last, o_busy, o_done;
  modport master (
    output en, i_start, i_abort, i_base, i_len, i_stride, i_dwell, i_pause, i_repeat, i_loop,
    input o_addr, o_valid, o_last, o_busy, o_done
  );
  modport slave (
    input en, i_start, i_abort, i_base, i_len, i_stride, i_dwell, i_pause, i_repeat, i_loop,
    output o_addr, o_valid, o_last, o_busy, o_done
  );
endinterface

// File: rtl/addr_gen_timer.sv
// addr_gen_timer: loadable down-counter shared by the dwell and pause phases
module addr_gen_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/addr_gen_seq.sv
// addr_gen_seq: strided address sequencer with dwell/pause timing and multi-pass repeat
module addr_gen_seq
  import addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int STRIDE_W = 8,
  parameter int CNT_W = 8,
  parameter int REP_W = 4
) (
  input logic clk,
  input logic rst,
  addr_gen_seq_if.slave bus
);
  localparam int TW = ctr_w((1 << CNT_W) - 1);
  state_t state;
  logic [ADDR_WIDTH-1:0] addr, base_q, len_q, idx;
  logic [STRIDE_W-1:0] stride_q;
  logic [CNT_W-1:0] dwell_q, pause_q;
  logic [REP_W-1:0] rep_q, pass;
  logic loop_q, busy, last_idx, more_pass, start_ok, to_pause, step;
  logic tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val;
  // timer is loaded with period-1 so the zero flag marks the final cycle of a phase
  always_comb begin
    busy = state == DWELL || state == PAUSE;
    last_idx = idx == len_q - ADDR_WIDTH'(1);
    more_pass = loop_q || pass < rep_q;
    start_ok = bus.i_start && (state == IDLE || (state == DONE && bus.en));
    to_pause = bus.en && tmr_zero && state == DWELL && pause_q != '0;
    step = bus.en && tmr_zero && ((state == DWELL && pause_q == '0) || state == PAUSE);
    tmr_load = bus.i_abort || start_ok || to_pause || (step && (!last_idx || more_pass));
    tmr_val = bus.i_abort ? '0
            : start_ok ? TW'(bus.i_dwell - CNT_W'(bus.i_dwell != '0))
            : to_pause ? TW'(pause_q - CNT_W'(1))
            : TW'(dwell_q - CNT_W'(dwell_q != '0));
    tmr_dec = bus.en && busy;
  end
  addr_gen_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load(tmr_load), .load_val(tmr_val), .dec(tmr_dec), .zero(tmr_zero)
  );
  always_ff @(posedge clk) begin
    if (rst || bus.i_abort) begin
      state <= IDLE;
      addr <= '0;
      idx <= '0;
      pass <= '0;
      base_q <= '0;
      len_q <= '0;
      stride_q <= '0;
      dwell_q <= '0;
      pause_q <= '0;
      rep_q <= '0;
      loop_q <= 1'b0;
    end else if (start_ok) begin
      state <= bus.i_len == '0 ? DONE : DWELL;
      addr <= bus.i_base;
      idx <= '0;
      pass <= '0;
      base_q <= bus.i_base;
      len_q <= bus.i_len;
      stride_q <= bus.i_stride;
      dwell_q <= bus.i_dwell;
      pause_q <= bus.i_pause;
      rep_q <= bus.i_repeat;
      loop_q <= bus.i_loop;
    end else if (step) begin
      if (!last_idx) begin
        idx <= idx + ADDR_WIDTH'(1);
        addr <= addr + ADDR_WIDTH'(stride_q);
        state <= DWELL;
      end else if (more_pass) begin
        pass <= (&pass) ? pass : pass + REP_W'(1);
        idx <= '0;
        addr <= base_q;
        state <= DWELL;
      end else begin
        state <= DONE;
      end
    end else if (to_pause) begin
      state <= PAUSE;
    end else if (bus.en && state == DONE) begin
      state <= IDLE;
    end
  end
  assign bus.o_addr = addr;
  assign bus.o_valid = state == DWELL && bus.en;
  assign bus.o_last = bus.o_valid && last_idx;
  assign bus.o_busy = busy;
  assign bus.o_done = state == DONE && bus.en;
endmodule

// File: tb/tb_addr_gen_seq.sv
// tb_addr_gen_seq: randomized checks of addr_gen_seq against a per-enabled-cycle event model
module tb_addr_gen_seq;
  typedef struct {
    logic [11:0] b, l;
    logic [7:0] s, d, p;
    logic [3:0] r;
    bit lp;
  } cfg_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  addr_gen_seq_if bus ();
  addr_gen_seq dut (.clk(clk), .rst(rst), .bus(bus));
  // event word: [15] busy, [14] valid, [13] last, [12] done, [11:0] addr
  logic [15:0] exp_q[$];
  logic [15:0] ex, ob;
  int compared = 0;
  int mismatched = 0;

  function automatic void build(input cfg_t c, input int lpn);
    int np = c.lp ? lpn : int'(c.r) + 1;
    logic [11:0] a;
    exp_q.delete();
    for (int q = 0; q < np && c.l != 0; q++)
      for (int i = 0; i < int'(c.l); i++) begin
        a = 12'((int'(c.b) + i * int'(c.s)) % 4096);
        for (int k = 0; k < (c.d == 0 ? 1 : int'(c.d)); k++)
          exp_q.push_back({1'b1, 1'b1, i == int'(c.l) - 1, 1'b0, a});
        for (int k = 0; k < int'(c.p); k++) exp_q.push_back({4'b1000, a});
      end
    if (!c.lp) begin
      exp_q.push_back(16'h1000);
      exp_q.push_back(16'h0000);
    end
  endfunction

  function automatic logic [15:0] head();
    logic [15:0] e = exp_q.size() != 0 ? exp_q[0] : 16'h0;
    if (!bus.en) e[14:12] = 3'b000;
    return e;
  endfunction

  function automatic logic [15:0] obs();
    return {bus.o_busy, bus.o_valid, bus.o_last, bus.o_done, bus.o_busy ? bus.o_addr : 12'h000};
  endfunction

  function automatic cfg_t rnd_cfg(input int minlen);
    cfg_t c;
    c.b = 12'($urandom);
    c.l = 12'($urandom_range(minlen, 5));
    c.s = 8'($urandom);
    c.d = 8'($urandom_range(0, 3));
    c.p = 8'($urandom_range(0, 2));
    c.r = 4'($urandom_range(0, 2));
    c.lp = 1'b0;
    return c;
  endfunction

  task automatic drive_cfg(input cfg_t c);
    bus.i_base = c.b;
    bus.i_len = c.l;
    bus.i_stride = c.s;
    bus.i_dwell = c.d;
    bus.i_pause = c.p;
    bus.i_repeat = c.r;
    bus.i_loop = c.lp;
  endtask

  task automatic start(input cfg_t c);
    @(negedge clk);
    drive_cfg(c);
    bus.en = 1;
    bus.i_start = 1;
    @(negedge clk);
    bus.i_start = 0;
    bus.i_base = 12'($urandom);
    bus.i_len = 12'($urandom);
    bus.i_stride = 8'($urandom);
    bus.i_dwell = 8'($urandom);
    bus.i_pause = 8'($urandom);
    bus.i_repeat = 4'($urandom);
    bus.i_loop = 1'($urandom);
  endtask

  task automatic test_reset();
    bus.en = 1;
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if ({bus.o_busy, bus.o_valid, bus.o_last, bus.o_done, bus.o_addr} !== 16'h0) begin
      mismatched++;
      $display("FAIL reset: got %h want 0000", {bus.o_busy, bus.o_valid, bus.o_last, bus.o_done, bus.o_addr});
    end
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      compared++;
      if (obs() !== 16'h0) begin
        mismatched++;
        $display("FAIL reset_idle: got %h want 0000", obs());
      end
    end
  endtask

  task automatic test_patterns();
    cfg_t t[$];
    t.push_back('{12'h000, 12'd4, 8'd1, 8'd8, 8'd2, 4'd0, 1'b0});
    t.push_back('{12'hFFE, 12'd3, 8'd3, 8'd1, 8'd0, 4'd0, 1'b0});
    t.push_back('{12'h123, 12'd0, 8'd5, 8'd4, 8'd1, 4'd0, 1'b0});
    t.push_back('{12'h010, 12'd3, 8'd16, 8'd0, 8'd1, 4'd0, 1'b0});
    foreach (t[n]) begin
      build(t[n], 0);
      start(t[n]);
      while (exp_q.size() != 0) begin
        bus.en = 1;
        #1;
        ex = head();
        ob = obs();
        compared++;
        if (ob !== ex) begin
          mismatched++;
          $display("FAIL pattern%0d: got %h want %h (left %0d)", n, ob, ex, exp_q.size());
        end
        void'(exp_q.pop_front());
        @(negedge clk);
      end
    end
  endtask

  task automatic test_repeat_loop();
    cfg_t c = '{12'h005, 12'd2, 8'd2, 8'd2, 8'd0, 4'd2, 1'b0};
    build(c, 0);
    start(c);
    while (exp_q.size() != 0) begin
      bus.en = 1;
      #1;
      ex = head();
      ob = obs();
      compared++;
      if (ob !== ex) begin
        mismatched++;
        $display("FAIL repeat: got %h want %h", ob, ex);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    c = '{12'hFFF, 12'd2, 8'd1, 8'd1, 8'd0, 4'd0, 1'b1};
    build(c, 60);
    start(c);
    for (int i = 0; i <= 60; i++) begin
      bus.en = $urandom_range(0, 3) != 0;
      bus.i_abort = i == 60;
      #1;
      ex = head();
      ob = obs();
      compared++;
      if (ob !== ex) begin
        mismatched++;
        $display("FAIL loop cyc %0d: got %h want %h", i, ob, ex);
      end
      if (bus.en) void'(exp_q.pop_front());
      @(negedge clk);
    end
    bus.i_abort = 0;
    exp_q.delete();
    repeat (4) begin
      bus.en = 1;
      #1;
      compared++;
      if (obs() !== 16'h0) begin
        mismatched++;
        $display("FAIL abort: got %h want 0000", obs());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_en_stall();
    cfg_t c = '{12'h020, 12'd3, 8'd4, 8'd8, 8'd2, 4'd0, 1'b0};
    int n_ev, iters;
    build(c, 0);
    n_ev = exp_q.size();
    iters = 0;
    start(c);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      bus.en = !((i >= 3 && i <= 5) || (i >= 12 && i <= 14));
      #1;
      ex = head();
      ob = obs();
      compared++;
      if (ob !== ex) begin
        mismatched++;
        $display("FAIL stall cyc %0d: got %h want %h", i, ob, ex);
      end
      if (bus.en) void'(exp_q.pop_front());
      iters++;
      @(negedge clk);
    end
    compared++;
    if (iters != n_ev + 6) begin
      mismatched++;
      $display("FAIL stall_len: got %0d cycles want %0d", iters, n_ev + 6);
    end
  endtask

  task automatic test_back_to_back();
    cfg_t a = '{12'h200, 12'd3, 8'd8, 8'd2, 8'd1, 4'd0, 1'b0};
    cfg_t b = rnd_cfg(1);
    bit restart = 1;
    build(a, 0);
    start(a);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      bus.en = 1;
      bus.i_start = 0;
      if (i == 2) begin
        drive_cfg(rnd_cfg(0));
        bus.i_start = 1;
      end
      if (restart && exp_q[0][12]) begin
        drive_cfg(b);
        bus.i_start = 1;
      end
      #1;
      ex = head();
      ob = obs();
      compared++;
      if (ob !== ex) begin
        mismatched++;
        $display("FAIL b2b cyc %0d: got %h want %h", i, ob, ex);
      end
      if (restart && exp_q[0][12]) begin
        restart = 0;
        build(b, 0);
      end else void'(exp_q.pop_front());
      @(negedge clk);
    end
    bus.i_start = 0;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_timeout: %0d events left want 0", exp_q.size());
    end
    a = '{12'h3A0, 12'd5, 8'd1, 8'd3, 8'd1, 4'd1, 1'b0};
    start(a);
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    compared++;
    if ({bus.o_busy, bus.o_valid, bus.o_last, bus.o_done, bus.o_addr} !== 16'h0) begin
      mismatched++;
      $display("FAIL rst_mid: got %h want 0000", {bus.o_busy, bus.o_valid, bus.o_last, bus.o_done, bus.o_addr});
    end
    @(negedge clk);
    #1;
    compared++;
    if (obs() !== 16'h0) begin
      mismatched++;
      $display("FAIL rst_after: got %h want 0000", obs());
    end
  endtask

  task automatic test_random();
    cfg_t c;
    for (int n = 0; n < 8; n++) begin
      c = rnd_cfg(0);
      build(c, 0);
      start(c);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
        bus.en = $urandom_range(0, 3) != 0;
        #1;
        ex = head();
        ob = obs();
        compared++;
        if (ob !== ex) begin
          mismatched++;
          $display("FAIL random%0d cyc %0d: got %h want %h", n, i, ob, ex);
        end
        if (bus.en) void'(exp_q.pop_front());
        @(negedge clk);
      end
      compared++;
      if (exp_q.size() != 0) begin
        mismatched++;
        $display("FAIL random_timeout: %0d events left want 0", exp_q.size());
      end
    end
  endtask

  initial begin
    bus.en = 0;
    bus.i_start = 0;
    bus.i_abort = 0;
    drive_cfg('{12'h0, 12'h0, 8'h0, 8'h0, 8'h0, 4'h0, 1'b0});
    test_reset();
    test_patterns();
    test_repeat_loop();
    test_en_stall();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
